// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file port arbiter: lock FSM
// encodings, default widths, requester ids and a grant helper.
package rf_arb_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 32;

    localparam logic RQ0_ID = 1'b0;
    localparam logic RQ1_ID = 1'b1;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    // One-hot grant vector for a requester id.
    function automatic logic [1:0] id_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rf_port_arbiter_if.sv
// Requester-side bus of the register-file arbiter: two request ports,
// the shared response path and the lock ownership indication.
interface rf_port_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          rq0_valid, rq0_ready, rq0_lock, rq0_we;
    logic [AW-1:0] rq0_rda, rq0_rdb, rq0_wa;
    logic [DW-1:0] rq0_wd;

    logic          rq1_valid, rq1_ready, rq1_lock, rq1_we;
    logic [AW-1:0] rq1_rda, rq1_rdb, rq1_wa;
    logic [DW-1:0] rq1_wd;

    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_a, rsp_b;
    logic [1:0]    owner;

    modport master (
        output rq0_valid, rq0_lock, rq0_we, rq0_rda, rq0_rdb, rq0_wa, rq0_wd,
        output rq1_valid, rq1_lock, rq1_we, rq1_rda, rq1_rdb, rq1_wa, rq1_wd,
        input  rq0_ready, rq1_ready, rsp0_valid, rsp1_valid, rsp_a, rsp_b, owner
    );

    modport slave (
        input  rq0_valid, rq0_lock, rq0_we, rq0_rda, rq0_rdb, rq0_wa, rq0_wd,
        input  rq1_valid, rq1_lock, rq1_we, rq1_rda, rq1_rdb, rq1_wa, rq1_wd,
        output rq0_ready, rq1_ready, rsp0_valid, rsp1_valid, rsp_a, rsp_b, owner
    );
endinterface

// File: rtl/rf_port_arbiter_rr_arb2.sv
// Two-way round-robin picker. When force_en is set only force_id may win
// (used while a lock is held); otherwise a lone valid wins and a tie goes
// to the requester named by prio.
module rr_arb2
    import rf_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       prio,
    input  logic       force_en,
    input  logic       force_id,
    output logic [1:0] grant,
    output logic       gid
);

    // Pick the winner for this cycle.
    always_comb begin
        grant = 2'b00;
        gid   = RQ0_ID;
        if (force_en) begin
            if (valid[force_id]) begin
                grant = id_onehot(force_id);
                gid   = force_id;
            end else begin
                grant = 2'b00;
                gid   = RQ0_ID;
            end
        end else begin
            case (valid)
                2'b01: begin
                    grant = id_onehot(RQ0_ID);
                    gid   = RQ0_ID;
                end
                2'b10: begin
                    grant = id_onehot(RQ1_ID);
                    gid   = RQ1_ID;
                end
                2'b11: begin
                    grant = id_onehot(prio);
                    gid   = prio;
                end
                default: begin
                    grant = 2'b00;
                    gid   = RQ0_ID;
                end
            endcase
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Register-file port arbiter: grants one beat per cycle to the core
// pipeline (rq0) or the debug/load unit (rq1), supports locked multi-beat
// ownership, steers the granted request onto the register file and flags
// the registered read data for the requester that issued the beat.
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
)(
    input  logic                clk,
    input  logic                rst_f,
    rf_port_arbiter_if.slave    bus,
    output logic [AW-1:0]       rf_rega,
    output logic [AW-1:0]       rf_regb,
    output logic [AW-1:0]       rf_wreg,
    output logic [DW-1:0]       rf_wdata,
    output logic                rf_we,
    input  logic [DW-1:0]       rf_rsa,
    input  logic [DW-1:0]       rf_rsb
);

    arb_state_e state_r, state_s;
    logic       prio_r, prio_s;
    logic       rsp0_valid_r, rsp1_valid_r;
    logic [1:0] valid_s, grant_s;
    logic       gid_s, accept_s, lock_s;

    // No grant is issued while reset is asserted.
    assign valid_s  = {bus.rq1_valid & rst_f, bus.rq0_valid & rst_f};
    assign accept_s = |grant_s;
    assign lock_s   = gid_s ? bus.rq1_lock : bus.rq0_lock;

    rr_arb2 u_rr_arb2 (
        .valid    (valid_s),
        .prio     (prio_r),
        .force_en (state_r != ARB),
        .force_id (state_r == LOCK1),
        .grant    (grant_s),
        .gid      (gid_s)
    );

    // Lock FSM next state and round-robin priority update.
    always_comb begin
        state_s = state_r;
        prio_s  = prio_r;
        if (accept_s) begin
            prio_s = ~gid_s;
        end else begin
            prio_s = prio_r;
        end
        case (state_r)
            ARB: begin
                if (accept_s && lock_s) begin
                    state_s = gid_s ? LOCK1 : LOCK0;
                end else begin
                    state_s = ARB;
                end
            end
            LOCK0, LOCK1: begin
                if (accept_s && !lock_s) begin
                    state_s = ARB;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = ARB;
        endcase
    end

    // Steer the granted requester onto the register file, zero when idle.
    always_comb begin
        rf_rega  = '0;
        rf_regb  = '0;
        rf_wreg  = '0;
        rf_wdata = '0;
        rf_we    = 1'b0;
        if (accept_s) begin
            if (gid_s) begin
                rf_rega  = bus.rq1_rda;
                rf_regb  = bus.rq1_rdb;
                rf_wreg  = bus.rq1_wa;
                rf_wdata = bus.rq1_wd;
                rf_we    = bus.rq1_we;
            end else begin
                rf_rega  = bus.rq0_rda;
                rf_regb  = bus.rq0_rdb;
                rf_wreg  = bus.rq0_wa;
                rf_wdata = bus.rq0_wd;
                rf_we    = bus.rq0_we;
            end
        end else begin
            rf_we = 1'b0;
        end
    end

    // State, priority and one-cycle-delayed response strobes.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_r      <= ARB;
            prio_r       <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            prio_r       <= prio_s;
            rsp0_valid_r <= grant_s[0];
            rsp1_valid_r <= grant_s[1];
        end
    end

    assign bus.rq0_ready  = grant_s[0];
    assign bus.rq1_ready  = grant_s[1];
    assign bus.rsp0_valid = rsp0_valid_r;
    assign bus.rsp1_valid = rsp1_valid_r;
    assign bus.rsp_a      = rf_rsa;
    assign bus.rsp_b      = rf_rsb;
    assign bus.owner      = {state_r != ARB, state_r == LOCK1};

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Self-checking bench for rf_port_arbiter: a behavioural register file,
// a reference model of the arbitration rules, a vector table, directed
// corner-case sequences and a randomized run.
module tb_rf_port_arbiter;
    import rf_arb_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_f;
    logic [AW-1:0] rf_rega, rf_regb, rf_wreg;
    logic [DW-1:0] rf_wdata, rf_rsa, rf_rsb;
    logic          rf_we;

    always #5 clk = ~clk;

    rf_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    rf_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .bus      (bus),
        .rf_rega  (rf_rega),
        .rf_regb  (rf_regb),
        .rf_wreg  (rf_wreg),
        .rf_wdata (rf_wdata),
        .rf_we    (rf_we),
        .rf_rsa   (rf_rsa),
        .rf_rsb   (rf_rsb)
    );

    // Register file: registered reads, R0 reads zero, read-before-write.
    logic [DW-1:0] rf_mem [16];
    always @(posedge clk) begin
        rf_rsa <= (rf_rega == 4'd0) ? 32'd0 : rf_mem[rf_rega];
        rf_rsb <= (rf_regb == 4'd0) ? 32'd0 : rf_mem[rf_regb];
        if (rf_we) rf_mem[rf_wreg] <= rf_wdata;
    end

    // Reference model state.
    int          m_lock;   // -1 = none, else locking requester id
    int          m_prio;
    int          m_pend;   // -1 = no response due, else requester id
    logic [31:0] m_pa, m_pb;
    logic [31:0] ref_mem [16];

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    typedef struct {
        logic       v0, v1, l0, l1;
        logic       r0, r1;
        logic [1:0] own;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.rq0_valid = 1'b0; bus.rq0_lock = 1'b0; bus.rq0_we = 1'b0;
        bus.rq0_rda = 4'd0; bus.rq0_rdb = 4'd0; bus.rq0_wa = 4'd0; bus.rq0_wd = 32'd0;
        bus.rq1_valid = 1'b0; bus.rq1_lock = 1'b0; bus.rq1_we = 1'b0;
        bus.rq1_rda = 4'd0; bus.rq1_rdb = 4'd0; bus.rq1_wa = 4'd0; bus.rq1_wd = 32'd0;
    endtask

    task automatic set_rq(input int id, input logic v, input logic lk, input logic we,
                          input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] wa, input logic [31:0] wd);
        if (id == 0) begin
            bus.rq0_valid = v; bus.rq0_lock = lk; bus.rq0_we = we;
            bus.rq0_rda = ra; bus.rq0_rdb = rb; bus.rq0_wa = wa; bus.rq0_wd = wd;
        end else begin
            bus.rq1_valid = v; bus.rq1_lock = lk; bus.rq1_we = we;
            bus.rq1_rda = ra; bus.rq1_rdb = rb; bus.rq1_wa = wa; bus.rq1_wd = wd;
        end
    endtask

    // Check one cycle against the model, then advance model and clock.
    task automatic do_cycle();
        int g;
        logic [1:0] v;
        logic [3:0] ra, rb, wa;
        logic [31:0] wd;
        logic we, lk;
        #2;
        v = {bus.rq1_valid, bus.rq0_valid};
        if (!rst_f) g = -1;
        else if (m_lock >= 0) g = v[m_lock] ? m_lock : -1;
        else if (v == 2'b11) g = m_prio;
        else if (v == 2'b01) g = 0;
        else if (v == 2'b10) g = 1;
        else g = -1;

        chk("rq0_ready", 32'(bus.rq0_ready), 32'(g == 0));
        chk("rq1_ready", 32'(bus.rq1_ready), 32'(g == 1));
        chk("owner", 32'(bus.owner), (m_lock < 0) ? 32'd0 : 32'(2 + m_lock));
        chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(m_pend == 0));
        chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(m_pend == 1));
        if (m_pend >= 0) begin
            chk("rsp_a", bus.rsp_a, m_pa);
            chk("rsp_b", bus.rsp_b, m_pb);
        end

        if (g == 1) begin
            ra = bus.rq1_rda; rb = bus.rq1_rdb; wa = bus.rq1_wa; wd = bus.rq1_wd;
            we = bus.rq1_we; lk = bus.rq1_lock;
        end else begin
            ra = bus.rq0_rda; rb = bus.rq0_rdb; wa = bus.rq0_wa; wd = bus.rq0_wd;
            we = bus.rq0_we; lk = bus.rq0_lock;
        end
        if (g >= 0) begin
            chk("rf_rega", 32'(rf_rega), 32'(ra));
            chk("rf_regb", 32'(rf_regb), 32'(rb));
            chk("rf_wreg", 32'(rf_wreg), 32'(wa));
            chk("rf_wdata", rf_wdata, wd);
            chk("rf_we", 32'(rf_we), 32'(we));
        end else begin
            chk("rf_we_idle", 32'(rf_we), 32'd0);
            chk("rf_rega_idle", 32'(rf_rega), 32'd0);
            chk("rf_wdata_idle", rf_wdata, 32'd0);
        end

        if (!rst_f) begin
            m_lock = -1; m_prio = 0; m_pend = -1;
        end else if (g >= 0) begin
            m_pa = (ra == 4'd0) ? 32'd0 : ref_mem[ra];
            m_pb = (rb == 4'd0) ? 32'd0 : ref_mem[rb];
            m_pend = g;
            if (we) ref_mem[wa] = wd;
            m_prio = 1 - g;
            if (m_lock < 0 && lk) m_lock = g;
            else if (m_lock >= 0 && !lk) m_lock = -1;
        end else begin
            m_pend = -1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_f = 1'b0;
        do_cycle();
        rst_f = 1'b1;
    endtask

    initial begin
        logic [31:0] val;
        m_lock = -1; m_prio = 0; m_pend = -1;
        rst_f = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        // Reset state.
        chk("reset_rq0_ready", 32'(bus.rq0_ready), 32'd0);
        chk("reset_owner", 32'(bus.owner), 32'd0);
        chk("reset_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        chk("reset_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_rf_wreg", 32'(rf_wreg), 32'd0);
        rst_f = 1'b1;

        // Preload R1..R15 through the debug/load port.
        for (int i = 1; i < 16; i++) begin
            case (i)
                3: val = 32'h11;
                4: val = 32'h1;
                5: val = 32'h22;
                default: val = $urandom;
            endcase
            idle_inputs();
            set_rq(1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'(i), val);
            do_cycle();
        end
        idle_inputs();
        do_cycle();

        // rq0 alone reads R3/R5.
        do_reset();
        set_rq(0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd5, 4'd0, 32'd0);
        #1 chk("t1_ready_same_cycle", 32'(bus.rq0_ready), 32'd1);
        do_cycle();
        idle_inputs();
        chk("t1_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("t1_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        chk("t1_rsp_a", bus.rsp_a, 32'h11);
        chk("t1_rsp_b", bus.rsp_b, 32'h22);
        do_cycle();

        // Vector table: alternation, lock entry, idle-in-lock, release.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
        idle_inputs();
        do_reset();
        for (int i = 0; i < 13; i++) begin
            set_rq(0, tbl[i].v0, tbl[i].l0, 1'b0, 4'($urandom), 4'($urandom), 4'd0, 32'd0);
            set_rq(1, tbl[i].v1, tbl[i].l1, 1'b0, 4'($urandom), 4'($urandom), 4'd0, 32'd0);
            #1;
            chk("tbl_r0", 32'(bus.rq0_ready), 32'(tbl[i].r0));
            chk("tbl_r1", 32'(bus.rq1_ready), 32'(tbl[i].r1));
            chk("tbl_owner", 32'(bus.owner), 32'(tbl[i].own));
            do_cycle();
        end

        // rq1 locked writes of R7 while rq0 keeps requesting.
        idle_inputs();
        set_rq(0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 32'd0);
        do_cycle();
        for (int i = 0; i < 4; i++) begin
            set_rq(1, 1'b1, (i < 3), 1'b1, 4'd0, 4'd0, 4'd7, 32'hA5A5A5A5);
            if (i > 0) begin
                #1 chk("lock7_owner", 32'(bus.owner), 32'd3);
                chk("lock7_rq0_blocked", 32'(bus.rq0_ready), 32'd0);
            end
            do_cycle();
        end
        idle_inputs();
        set_rq(0, 1'b1, 1'b0, 1'b0, 4'd7, 4'd7, 4'd0, 32'd0);
        set_rq(1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd0);
        #1 chk("lock7_release_rq0", 32'(bus.rq0_ready), 32'd1);
        do_cycle();
        idle_inputs();
        chk("lock7_read_back", bus.rsp_a, 32'hA5A5A5A5);
        do_cycle();

        // Read-before-write within a beat, new value on the next beat.
        set_rq(0, 1'b1, 1'b0, 1'b1, 4'd4, 4'd4, 4'd4, 32'hDEAD);
        do_cycle();
        set_rq(0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd0, 4'd0, 32'd0);
        chk("rbw_old", bus.rsp_a, 32'h1);
        do_cycle();
        idle_inputs();
        chk("rbw_new", bus.rsp_a, 32'hDEAD);
        do_cycle();

        // Reset while LOCK0 is held and a response is pending.
        do_reset();
        set_rq(0, 1'b1, 1'b1, 1'b1, 4'd2, 4'd3, 4'd9, 32'h5555);
        do_cycle();
        rst_f = 1'b0;
        set_rq(0, 1'b1, 1'b1, 1'b1, 4'd2, 4'd3, 4'd9, 32'h6666);
        do_cycle();
        rst_f = 1'b1;
        idle_inputs();
        chk("rst_lock_owner", 32'(bus.owner), 32'd0);
        chk("rst_lock_rsp0", 32'(bus.rsp0_valid), 32'd0);
        chk("rst_lock_rf_we", 32'(rf_we), 32'd0);
        do_cycle();

        // Lock survives idle cycles of its owner.
        set_rq(0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1, 4'd0, 32'd0);
        set_rq(1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd2, 4'd0, 32'd0);
        do_cycle();
        bus.rq0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("idle_lock_rq1_blocked", 32'(bus.rq1_ready), 32'd0);
            do_cycle();
        end
        set_rq(0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 4'd0, 32'd0);
        do_cycle();
        bus.rq0_valid = 1'b0;
        #1 chk("idle_lock_rq1_after", 32'(bus.rq1_ready), 32'd1);
        do_cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst_f = ($urandom_range(99) != 0);
            for (int id = 0; id < 2; id++) begin
                set_rq(id, ($urandom_range(9) < 7), ($urandom_range(9) < 3),
                       1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), $urandom);
            end
            do_cycle();
        end
        rst_f = 1'b1;
        idle_inputs();
        do_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Shares the single-write / dual-read register file between two requesters: requester 0 is the core pipeline and requester 1 is the debug/load unit.
- Grants one access per cycle to one requester, chosen round-robin.
- Supports a lock, so one requester can keep the file for an atomic multi-beat sequence.
- Drives the register file address, write-data and write-enable inputs, and routes its registered read data back to the requester that owns it, with a response-valid strobe.

Parameters:
- AW, 4, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_f  in  1  reset, synchronous, active-low.
- rq0_valid / rq1_valid  in  1  request valid.
- rq0_ready / rq1_ready  out  1  grant; a beat is accepted when valid & ready.
- rq0_lock / rq1_lock  in  1  keep ownership after this beat.
- rq0_rda, rq0_rdb / rq1_rda, rq1_rdb  in  AW  read addresses A/B.
- rq0_we / rq1_we  in  1  write request.
- rq0_wa / rq1_wa  in  AW  write address.
- rq0_wd / rq1_wd  in  DW  write data.
- rf_rega, rf_regb  out  AW  to register file read addresses.
- rf_wreg  out  AW  to register file write address.
- rf_wdata  out  DW  to register file write data.
- rf_we  out  1  to register file write enable.
- rf_rsa, rf_rsb  in  DW  from register file, registered read data.
- rsp0_valid / rsp1_valid  out  1  read data for that requester is valid this cycle.
- rsp_a, rsp_b  out  DW  response data, pass-through of rf_rsa / rf_rsb.
- owner  out  2  bit1 = lock held, bit0 = id of locking requester.

Behaviour:
- Reset (rst_f=0 at posedge): state=ARB, prio=0, rsp0_valid=rsp1_valid=0, owner=0.
  - Combinational outputs with no grant: ready=0, rf_we=0, rf_rega=rf_regb=rf_wreg=0, rf_wdata=0.
  - Reset mid-lock or mid-response drops everything; a response pending from the prior cycle is discarded (rsp valids forced 0).
- States:
  - ARB: no lock held.
  - LOCK0: only rq0 may be granted.
  - LOCK1: only rq1 may be granted.
- ARB grant (combinational, same cycle as valid):
  - Only one valid: grant it.
  - Both valid: grant rq[prio].
  - Neither valid: no grant, prio unchanged.
  - After any accepted beat, prio <= ~granted id.
- Entering a lock: an accepted beat with lock=1 moves the state to LOCKi.
- LOCKi rules:
  - ready_i = valid_i; ready of the other requester = 0.
  - Idle cycles (valid_i=0) keep the lock.
  - An accepted beat with lock=0 returns to ARB, with prio <= ~i.
- Datapath on a granted beat: rf_rega/regb/wreg/wdata are muxed from the granted requester, and rf_we = granted we. No register stage, zero added latency.
- Read latency:
  - Beat accepted in cycle t; the register file latches at the end of t.
  - rspI_valid=1 in cycle t+1, with rsp_a/rsp_b = rf_rsa/rf_rsb.
  - The response is for requester I only.
  - Every accepted beat produces a response, even if it is write-only (data is don't-care).
- Ordering:
  - Read and write to the same address in the same beat returns the OLD value (read-before-write).
  - A read in beat t+1 after a write at t returns the NEW value, regardless of which requester wrote.
- Register R0 reads as 0 at the register file; a write to R0 is forwarded unchanged (no filtering).
- Back-to-back beats by alternating requesters in consecutive cycles are allowed; at most one rsp valid is high per cycle.
- rq*_ready never depends on rsp state (no backpressure on responses).

Decomposition:
- Shared package rf_arb_pkg:
  - State encodings ARB=2'd0, LOCK0=2'd1, LOCK1=2'd2.
  - Default AW/DW.
  - Requester ids.
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: valid[1:0], prio, force_en, force_id.
  - Outputs: grant[1:0], gid.
- Lock FSM, request mux and response register stay in the top module.

Test Plan:
- Reset, then rq0 only:
  - Stimulus: rq0 rda=3, rdb=5 with R3=0x11, R5=0x22 preloaded.
  - Required: rq0_ready in the same cycle; next cycle rsp0_valid=1, rsp_a=0x11, rsp_b=0x22, rsp1_valid=0.
- Both valid for 4 cycles, no lock:
  - Required: grants alternate 0,1,0,1; rsp valids follow one cycle later with matching ids.
- rq1 lock=1 beats writing R7=0xA5A5A5A5, with rq0 valid throughout:
  - Required: rq0_ready=0 while owner=2'b11.
  - rq1 beat with lock=0 releases ownership; the next cycle rq0 is granted.
- rq0 beat we=1, wa=4, wd=0xDEAD, rda=4 in one beat (R4=0x1):
  - Required: rsp_a=0x1.
  - Next beat rda=4 -> rsp_a=0xDEAD.
- rst_f=0 during LOCK0 with a response pending:
  - Required: next cycle state=ARB, owner=0, rsp0_valid=0, rf_we=0.
- rq0 lock beat, then rq0_valid=0 for 3 cycles with rq1 valid:
  - Required: rq1 stays un-granted (lock held through idle cycles).
